// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-back, write-allocate word cache.
//
// Sits between a pipeline core port (I or D) and a slow block memory that
// answers with a one-cycle mem_ready pulse. Lines hold four 32-bit words.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   proc_read, proc_write    CPU request (write wins when both are set)
//   proc_addr[29:0]          word address: [1:0] offset, [INDEX_W+1:2] index, rest tag
//   proc_wdata[31:0]         CPU write data
//   proc_rdata[31:0]         read data, valid while requesting and not stalled
//   proc_stall               CPU must hold its request and inputs
//   mem_read, mem_write      block fetch / write-back request
//   mem_addr[27:0]           block address
//   mem_wdata[127:0]         write-back block, word k at [32k+31:32k]
//   mem_rdata[127:0]         fetched block, sampled on mem_ready
//   mem_ready                one-cycle completion pulse
module cache_ctrl #(
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [127:0]       data_q [LINES];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;

    // Block address of the miss being serviced. Registered so the memory-side
    // outputs depend only on state and registers.
    logic [27:0]        miss_blk;

    logic [1:0]         req_off;
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] miss_idx;
    logic               req;
    logic               hit;
    logic               wr_hit;
    logic               fill;

    assign req_off  = proc_addr[1:0];
    assign req_idx  = proc_addr[INDEX_W+1:2];
    assign req_tag  = proc_addr[29:INDEX_W+2];
    assign miss_idx = miss_blk[INDEX_W-1:0];
    assign req      = proc_read | proc_write;
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign fill     = (state == ALLOCATE) && mem_ready;

    // Next state and CPU-side outputs. Hit/miss response is combinational.
    always_comb begin
        state_nx   = state;
        proc_stall = 1'b0;
        proc_rdata = 32'd0;
        wr_hit     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        proc_rdata = data_q[req_idx][{req_off, 5'd0} +: 32];
                        wr_hit     = proc_write;
                    end else begin
                        proc_stall = 1'b1;
                        state_nx   = dirty_q[req_idx] ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                proc_stall = 1'b1;
                if (mem_ready) state_nx = ALLOCATE;
            end
            ALLOCATE: begin
                proc_stall = 1'b1;
                if (mem_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Memory-side outputs: Moore, held steady for the whole transfer.
    always_comb begin
        mem_read  = (state == ALLOCATE);
        mem_write = (state == WRITEBACK);
        mem_addr  = 28'd0;
        mem_wdata = 128'd0;
        if (state == WRITEBACK) begin
            mem_addr  = {tag_q[miss_idx], miss_idx};
            mem_wdata = data_q[miss_idx];
        end else if (state == ALLOCATE) begin
            mem_addr  = miss_blk;
        end
    end

    // Control state: the only things cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            miss_blk <= 28'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req && !hit)
                miss_blk <= proc_addr[29:2];
            if (wr_hit)
                dirty_q[req_idx] <= 1'b1;
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
                dirty_q[miss_idx] <= 1'b0;
            end
        end
    end

    // Data and tag storage, deliberately not reset. A write miss is merged on
    // the hit cycle that follows the fill, so the fill never needs a merge path.
    always_ff @(posedge clk) begin
        if (wr_hit)
            data_q[req_idx][{req_off, 5'd0} +: 32] <= proc_wdata;
        if (fill) begin
            data_q[miss_idx] <= mem_rdata;
            tag_q[miss_idx]  <= miss_blk[27:INDEX_W];
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: the bench plays the block memory and keeps a
// behavioural model (per-line words/tag/valid/dirty plus a sparse memory).
module tb_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         proc_read = 1'b0;
    logic         proc_write = 1'b0;
    logic [29:0]  proc_addr = '0;
    logic [31:0]  proc_wdata = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    // Behavioural model
    logic         mv [8];
    logic         md [8];
    logic [24:0]  mt [8];
    logic [127:0] ml [8];
    logic [127:0] mem_m [logic [27:0]];

    cache_ctrl #(.INDEX_W(3)) dut (
        .clk(clk), .rst(rst),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        proc_read = 1'b0;
        proc_write = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // One CPU request, serviced end to end. Called right after a negedge.
    // Delays: ready is pulsed on cycle index d of the state (<0 = random 0..3).
    task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] wd, input int wb_d, input int al_d,
                          output int stall_n, output int wb_n,
                          output logic [27:0] wb_addr, output logic [127:0] wb_data,
                          output logic [27:0] al_addr, output logic [31:0] rdata);
        logic [2:0]   idx;
        logic [24:0]  tg;
        logic [1:0]   off;
        logic [27:0]  blk;
        logic [27:0]  exp_addr;
        logic [127:0] exp_data;
        logic [31:0]  exp_word;
        bit           hit;
        bit           eff_wr;
        int           d;
        idx = a[4:2];
        tg  = a[29:5];
        off = a[1:0];
        blk = a[29:2];
        eff_wr = wr;
        hit = mv[idx] && (mt[idx] == tg);
        stall_n = 0;
        wb_n = 0;
        wb_addr = '0;
        wb_data = '0;
        al_addr = '0;
        rdata = '0;
        proc_read = rd;
        proc_write = wr;
        proc_addr = a;
        proc_wdata = wd;
        #1;
        if (!hit) begin
            total++;
            if (proc_stall !== 1'b1) begin
                bad++;
                $display("FAIL miss_stall addr=%0h act=%b exp=1", a, proc_stall);
            end
            if (proc_stall === 1'b1) stall_n++;
            @(negedge clk);
            if (md[idx]) begin
                exp_addr = {mt[idx], idx};
                exp_data = ml[idx];
                d = (wb_d < 0) ? int'($urandom_range(0, 3)) : wb_d;
                for (int i = 0; i <= d; i++) begin
                    #1;
                    total++;
                    if ({mem_write, mem_read, proc_stall} !== 3'b101) begin
                        bad++;
                        $display("FAIL wb_ctrl addr=%0h act=%b exp=101", a, {mem_write, mem_read, proc_stall});
                    end
                    total++;
                    if (mem_addr !== exp_addr || mem_wdata !== exp_data) begin
                        bad++;
                        $display("FAIL wb_data act=%0h/%0h exp=%0h/%0h", mem_addr, mem_wdata, exp_addr, exp_data);
                    end
                    if (proc_stall === 1'b1) stall_n++;
                    if (mem_write === 1'b1) wb_n++;
                    wb_addr = mem_addr;
                    wb_data = mem_wdata;
                    if (i == d) mem_ready = 1'b1;
                    @(negedge clk);
                    mem_ready = 1'b0;
                end
                mem_m[exp_addr] = exp_data;
            end
            if (!mem_m.exists(blk)) mem_m[blk] = rnd128();
            d = (al_d < 0) ? int'($urandom_range(0, 3)) : al_d;
            for (int i = 0; i <= d; i++) begin
                #1;
                total++;
                if ({mem_write, mem_read, proc_stall} !== 3'b011) begin
                    bad++;
                    $display("FAIL al_ctrl addr=%0h act=%b exp=011", a, {mem_write, mem_read, proc_stall});
                end
                total++;
                if (mem_addr !== blk) begin
                    bad++;
                    $display("FAIL al_addr act=%0h exp=%0h", mem_addr, blk);
                end
                if (proc_stall === 1'b1) stall_n++;
                al_addr = mem_addr;
                if (i == d) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_m[blk];
                end
                @(negedge clk);
                mem_ready = 1'b0;
                mem_rdata = rnd128();
            end
            ml[idx] = mem_m[blk];
            mt[idx] = tg;
            mv[idx] = 1'b1;
            md[idx] = 1'b0;
        end
        // Hit cycle (original hit, or the cycle after a fill).
        #1;
        total++;
        if ({proc_stall, mem_read, mem_write} !== 3'b000) begin
            bad++;
            $display("FAIL hit_ctrl addr=%0h act=%b exp=000", a, {proc_stall, mem_read, mem_write});
        end
        rdata = proc_rdata;
        exp_word = ml[idx][32*off +: 32];
        if (!eff_wr) begin
            total++;
            if (proc_rdata !== exp_word) begin
                bad++;
                $display("FAIL rdata addr=%0h act=%0h exp=%0h", a, proc_rdata, exp_word);
            end
        end else begin
            ml[idx][32*off +: 32] = wd;
            md[idx] = 1'b1;
        end
        @(negedge clk);
        proc_read = 1'b0;
        proc_write = 1'b0;
    endtask

    int           sn, wn;
    logic [27:0]  wa, aa;
    logic [127:0] wdat;
    logic [31:0]  rdv;

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({proc_stall, mem_read, mem_write} !== 3'b000 || proc_rdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs act=%b/%0h exp=000/0", {proc_stall, mem_read, mem_write}, proc_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_clean_miss();
        mem_m[28'h0] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
        access(1, 0, 30'h0, 32'h0, -1, 3, sn, wn, wa, wdat, aa, rdv);
        total++;
        if (sn !== 5 || wn !== 0 || aa !== 28'h0 || rdv !== 32'h1111) begin
            bad++;
            $display("FAIL clean_miss act=stall%0d wb%0d addr%0h data%0h exp=stall5 wb0 addr0 data1111", sn, wn, aa, rdv);
        end
        access(1, 0, 30'h3, 32'h0, -1, -1, sn, wn, wa, wdat, aa, rdv);
        total++;
        if (sn !== 0 || rdv !== 32'h4444) begin
            bad++;
            $display("FAIL read_hit act=stall%0d data%0h exp=stall0 data4444", sn, rdv);
        end
    endtask

    task automatic test_writeback();
        access(0, 1, 30'h1, 32'hDEAD, -1, -1, sn, wn, wa, wdat, aa, rdv);
        total++;
        if (sn !== 0) begin
            bad++;
            $display("FAIL write_hit_stall act=%0d exp=0", sn);
        end
        access(1, 0, 30'h20, 32'h0, 1, 2, sn, wn, wa, wdat, aa, rdv);
        total++;
        if (wn !== 2 || wa !== 28'h0 || wdat !== {32'h4444, 32'h3333, 32'hDEAD, 32'h1111} || aa !== 28'h8 || sn !== 6) begin
            bad++;
            $display("FAIL dirty_miss act=wb%0d %0h %0h al%0h stall%0d exp=wb2 0 4444_3333_dead_1111 al8 stall6", wn, wa, wdat, aa, sn);
        end
    endtask

    task automatic test_write_miss();
        access(0, 1, 30'h45, 32'hBEEF, -1, 0, sn, wn, wa, wdat, aa, rdv);
        total++;
        if (wn !== 0 || aa !== 28'h11 || sn !== 2) begin
            bad++;
            $display("FAIL write_miss act=wb%0d al%0h stall%0d exp=wb0 al11 stall2", wn, aa, sn);
        end
        access(1, 0, 30'h65, 32'h0, 0, 0, sn, wn, wa, wdat, aa, rdv);
        total++;
        if (wn !== 1 || wa !== 28'h11 || wdat[63:32] !== 32'hBEEF) begin
            bad++;
            $display("FAIL merged_evict act=wb%0d %0h word%0h exp=wb1 11 beef", wn, wa, wdat[63:32]);
        end
    endtask

    task automatic test_rst_mid_miss();
        access(0, 1, 30'h21, 32'hCAFE, -1, -1, sn, wn, wa, wdat, aa, rdv);
        proc_read = 1'b1;
        proc_addr = 30'h0;
        @(negedge clk);
        #1;
        total++;
        if (mem_write !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst_wb act=%b exp=1", mem_write);
        end
        rst = 1'b1;
        proc_read = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({mem_write, mem_read, proc_stall} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid act=%b exp=000", {mem_write, mem_read, proc_stall});
        end
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        access(1, 0, 30'h20, 32'h0, -1, -1, sn, wn, wa, wdat, aa, rdv);
        total++;
        if (wn !== 0 || sn < 2) begin
            bad++;
            $display("FAIL rst_reread act=wb%0d stall%0d exp=wb0 stall>=2", wn, sn);
        end
        access(1, 0, 30'h21, 32'h0, -1, -1, sn, wn, wa, wdat, aa, rdv);
    endtask

    task automatic test_rw_and_idle_ready();
        access(1, 1, 30'h22, 32'h1234_5678, -1, -1, sn, wn, wa, wdat, aa, rdv);
        access(1, 0, 30'h22, 32'h0, -1, -1, sn, wn, wa, wdat, aa, rdv);
        total++;
        if (sn !== 0 || rdv !== 32'h1234_5678) begin
            bad++;
            $display("FAIL both_is_write act=stall%0d data%0h exp=stall0 data12345678", sn, rdv);
        end
        mem_ready = 1'b1;
        mem_rdata = rnd128();
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        total++;
        if ({mem_write, mem_read, proc_stall} !== 3'b000) begin
            bad++;
            $display("FAIL idle_ready act=%b exp=000", {mem_write, mem_read, proc_stall});
        end
        @(negedge clk);
        access(1, 0, 30'h23, 32'h0, -1, -1, sn, wn, wa, wdat, aa, rdv);
        total++;
        if (sn !== 0) begin
            bad++;
            $display("FAIL idle_ready_hit act=stall%0d exp=0", sn);
        end
    endtask

    task automatic test_random();
        logic [29:0] a;
        bit rd, wr;
        for (int n = 0; n < 300; n++) begin
            a  = 30'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31));
            wr = ($urandom_range(0, 2) == 0);
            rd = !wr || ($urandom_range(0, 1) == 1);
            access(rd, wr, a, $urandom, -1, -1, sn, wn, wa, wdat, aa, rdv);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_miss();
        test_writeback();
        test_write_miss();
        test_rst_mid_miss();
        test_rw_and_idle_ready();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
